// File: rtl/qkv_token_sched.sv
// Token scheduler for a shared qkv projection engine: one engine start per accepted token,
// result presented downstream with its sequence index; sticky watchdog on engine completion.
module qkv_token_sched #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned EMBED_DIM   = 64,
    parameter int unsigned MAX_TOKENS  = 32,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned VEC_W      = DATA_WIDTH * EMBED_DIM,
    localparam int unsigned IDX_W      = (MAX_TOKENS > 1) ? $clog2(MAX_TOKENS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [VEC_W-1:0] tok_data,
    input  logic             tok_last,
    output logic             eng_start,
    output logic [VEC_W-1:0] eng_in_flat,
    input  logic             eng_done,
    input  logic [VEC_W-1:0] eng_q_flat,
    input  logic [VEC_W-1:0] eng_k_flat,
    input  logic [VEC_W-1:0] eng_v_flat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_q,
    output logic [VEC_W-1:0] out_k,
    output logic [VEC_W-1:0] out_v,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             seq_done,
    output logic             err
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_TOKENS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StOut,
        StErr
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;

    logic             w_accept;
    logic             w_capture;
    logic             w_timeout;
    logic             w_handshake;

    logic [VEC_W-1:0] r_eng_in;
    logic             r_last_pend;
    logic [CNT_W-1:0] r_wdog;
    logic [IDX_W-1:0] r_idx;
    logic [VEC_W-1:0] r_out_q;
    logic [VEC_W-1:0] r_out_k;
    logic [VEC_W-1:0] r_out_v;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_seq_done;
    logic             r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            StIdle: begin
                if (tok_valid && !r_err) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                w_state_nxt = StWait;
            end
            StWait: begin
                // A done pulse in the final watchdog cycle still counts as a completion.
                if (eng_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StOut;
                end else if (r_wdog == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StErr;
                end
            end
            StOut: begin
                if (r_out_valid && out_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            StErr: begin
                w_state_nxt = StErr;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eng_in    <= '0;
            r_last_pend <= 1'b0;
            r_wdog      <= '0;
            r_idx       <= '0;
            r_out_q     <= '0;
            r_out_k     <= '0;
            r_out_v     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_seq_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_seq_done <= 1'b0;

            if (w_accept) begin
                r_eng_in    <= tok_data;
                r_last_pend <= tok_last | (r_idx == IDX_LAST);
            end

            if (r_state == StIssue) begin
                r_wdog <= '0;
            end else if (r_state == StWait) begin
                r_wdog <= r_wdog + CNT_W'(1);
            end

            if (w_capture) begin
                r_out_q     <= eng_q_flat;
                r_out_k     <= eng_k_flat;
                r_out_v     <= eng_v_flat;
                r_out_last  <= r_last_pend;
                r_out_valid <= 1'b1;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (w_handshake) begin
                r_out_valid <= 1'b0;
                if (r_out_last) begin
                    r_seq_done <= 1'b1;
                    r_idx      <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign tok_ready   = (r_state == StIdle) && !r_err;
    assign eng_start   = (r_state == StIssue);
    assign eng_in_flat = r_eng_in;
    assign out_valid   = r_out_valid;
    assign out_q       = r_out_q;
    assign out_k       = r_out_k;
    assign out_v       = r_out_v;
    assign out_idx     = r_idx;
    assign out_last    = r_out_last;
    assign seq_done    = r_seq_done;
    assign err         = r_err;

endmodule
